// File: rtl/lsu.sv
// lsu -- load/store unit between the execute stage and the data cache.
//
// Accepts one memory operation at a time from execute (valid/ready), checks
// funct3 legality and address alignment, then issues a single word-indexed,
// byte-enabled request to the data cache. The request is held until the cache
// answers or TIMEOUT cycles elapse. The formatted load data, or a store
// acknowledge, is returned to writeback over a second valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_*_i / req_ready_o   operation from execute: store flag, funct3,
//                       byte address, store data, load destination register
//   dc_*_o              registered cache request: word address, read/write
//                       strobes, lane-replicated write data, byte enables
//   dc_rdata_i, dc_rvalid_i, dc_wvalid_i   cache answer (read/write hit)
//   resp_*_o / resp_ready_i   result to writeback: data, rd, error flag
module lsu #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_store_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic [31:0] dc_addr_o,
  output logic        dc_rreq_o,
  output logic        dc_wreq_o,
  output logic [31:0] dc_wdata_o,
  output logic [3:0]  dc_byte_enable_o,
  input  logic [31:0] dc_rdata_i,
  input  logic        dc_rvalid_i,
  input  logic        dc_wvalid_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic [4:0]  resp_rd_o,
  output logic        resp_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  offset_q, offset_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] dc_addr_q, dc_addr_d;
  logic        dc_rreq_q, dc_rreq_d;
  logic        dc_wreq_q, dc_wreq_d;
  logic [31:0] dc_wdata_q, dc_wdata_d;
  logic [3:0]  dc_be_q, dc_be_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic        resp_err_q, resp_err_d;

  logic        req_legal;
  logic        req_aligned;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_shifted;
  logic [31:0] ld_data;

  // Legality and alignment of the incoming operation; funct3[1:0] is the size.
  always_comb begin
    req_legal   = 1'b0;
    req_aligned = 1'b1;
    case (req_funct3_i)
      3'b000, 3'b001, 3'b010: req_legal = 1'b1;
      3'b100, 3'b101:         req_legal = !req_store_i;
      default:                req_legal = 1'b0;
    endcase
    case (req_funct3_i[1:0])
      2'b01:   req_aligned = !req_addr_i[0];
      2'b10:   req_aligned = (req_addr_i[1:0] == 2'b00);
      default: req_aligned = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone select
  // which bytes the cache writes.
  always_comb begin
    st_wdata = req_wdata_i;
    st_be    = 4'b1111;
    case (req_funct3_i[1:0])
      2'b00: begin
        st_wdata = {4{req_wdata_i[7:0]}};
        st_be    = 4'b0001 << req_addr_i[1:0];
      end
      2'b01: begin
        st_wdata = {2{req_wdata_i[15:0]}};
        st_be    = 4'b0011 << req_addr_i[1:0];
      end
      default: begin
        st_wdata = req_wdata_i;
        st_be    = 4'b1111;
      end
    endcase
  end

  // Load data: move the addressed byte/halfword down to bit 0, then extend.
  always_comb begin
    ld_shifted = dc_rdata_i >> {offset_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      3'b001:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      3'b100:  ld_data = {24'h0, ld_shifted[7:0]};
      3'b101:  ld_data = {16'h0, ld_shifted[15:0]};
      default: ld_data = ld_shifted;
    endcase
  end

  // Next-state logic. Cache strobes and response fields are registered so
  // they stay stable for the whole ACCESS/RESP phase and clear on exit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    funct3_d    = funct3_q;
    offset_d    = offset_q;
    rd_d        = rd_q;
    dc_addr_d   = dc_addr_q;
    dc_rreq_d   = dc_rreq_q;
    dc_wreq_d   = dc_wreq_q;
    dc_wdata_d  = dc_wdata_q;
    dc_be_d     = dc_be_q;
    resp_data_d = resp_data_q;
    resp_rd_d   = resp_rd_q;
    resp_err_d  = resp_err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          store_d  = req_store_i;
          funct3_d = req_funct3_i;
          offset_d = req_addr_i[1:0];
          rd_d     = req_rd_i;
          if (req_legal && req_aligned) begin
            state_d    = S_ACCESS;
            cnt_d      = '0;
            dc_addr_d  = {req_addr_i[31:2], 2'b00};
            dc_rreq_d  = !req_store_i;
            dc_wreq_d  = req_store_i;
            dc_wdata_d = req_store_i ? st_wdata : 32'h0;
            dc_be_d    = req_store_i ? st_be : 4'b0000;
          end else begin
            state_d     = S_RESP;
            resp_err_d  = 1'b1;
            resp_data_d = 32'h0;
            resp_rd_d   = req_store_i ? 5'd0 : req_rd_i;
          end
        end
      end

      // A hit in the same cycle as the timeout wins, so no error is flagged.
      S_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if ((store_q ? dc_wvalid_i : dc_rvalid_i) ||
            (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d     = S_RESP;
          cnt_d       = '0;
          dc_addr_d   = 32'h0;
          dc_rreq_d   = 1'b0;
          dc_wreq_d   = 1'b0;
          dc_wdata_d  = 32'h0;
          dc_be_d     = 4'b0000;
          resp_rd_d   = store_q ? 5'd0 : rd_q;
          if (store_q ? dc_wvalid_i : dc_rvalid_i) begin
            resp_err_d  = 1'b0;
            resp_data_d = store_q ? 32'h0 : ld_data;
          end else begin
            resp_err_d  = 1'b1;
            resp_data_d = 32'h0;
          end
        end
      end

      S_RESP: begin
        if (resp_ready_i) begin
          state_d     = S_IDLE;
          resp_data_d = 32'h0;
          resp_rd_d   = 5'd0;
          resp_err_d  = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      funct3_q    <= 3'b000;
      offset_q    <= 2'b00;
      rd_q        <= 5'd0;
      dc_addr_q   <= 32'h0;
      dc_rreq_q   <= 1'b0;
      dc_wreq_q   <= 1'b0;
      dc_wdata_q  <= 32'h0;
      dc_be_q     <= 4'b0000;
      resp_data_q <= 32'h0;
      resp_rd_q   <= 5'd0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      funct3_q    <= funct3_d;
      offset_q    <= offset_d;
      rd_q        <= rd_d;
      dc_addr_q   <= dc_addr_d;
      dc_rreq_q   <= dc_rreq_d;
      dc_wreq_q   <= dc_wreq_d;
      dc_wdata_q  <= dc_wdata_d;
      dc_be_q     <= dc_be_d;
      resp_data_q <= resp_data_d;
      resp_rd_q   <= resp_rd_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign req_ready_o      = (state_q == S_IDLE);
  assign resp_valid_o     = (state_q == S_RESP);
  assign dc_addr_o        = dc_addr_q;
  assign dc_rreq_o        = dc_rreq_q;
  assign dc_wreq_o        = dc_wreq_q;
  assign dc_wdata_o       = dc_wdata_q;
  assign dc_byte_enable_o = dc_be_q;
  assign resp_data_o      = resp_data_q;
  assign resp_rd_o        = resp_rd_q;
  assign resp_err_o       = resp_err_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu -- directed plus randomized bench for the load/store unit, checked
// against a behavioural model of the load/store formatting rules.
module tb_lsu;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid;
  logic        reqReady;
  logic        reqStore;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic [4:0]  reqRd;
  logic [31:0] dcAddr;
  logic        dcRreq;
  logic        dcWreq;
  logic [31:0] dcWdata;
  logic [3:0]  dcByteEnable;
  logic [31:0] dcRdata;
  logic        dcRvalid;
  logic        dcWvalid;
  logic        respValid;
  logic        respReady;
  logic [31:0] respData;
  logic [4:0]  respRd;
  logic        respErr;

  int checkCount = 0;
  int failCount  = 0;

  lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .rst_n            (rstN),
    .req_valid_i      (reqValid),
    .req_ready_o      (reqReady),
    .req_store_i      (reqStore),
    .req_funct3_i     (reqFunct3),
    .req_addr_i       (reqAddr),
    .req_wdata_i      (reqWdata),
    .req_rd_i         (reqRd),
    .dc_addr_o        (dcAddr),
    .dc_rreq_o        (dcRreq),
    .dc_wreq_o        (dcWreq),
    .dc_wdata_o       (dcWdata),
    .dc_byte_enable_o (dcByteEnable),
    .dc_rdata_i       (dcRdata),
    .dc_rvalid_i      (dcRvalid),
    .dc_wvalid_i      (dcWvalid),
    .resp_valid_o     (respValid),
    .resp_ready_i     (respReady),
    .resp_data_o      (respData),
    .resp_rd_o        (respRd),
    .resp_err_o       (respErr)
  );

  always #5 clk = ~clk;

  // Whether the operation is accepted for a cache access at all.
  function automatic bit modelOk(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
            (!st && ((f3 == 3'd4) || (f3 == 3'd5)));
    if (!legal) return 1'b0;
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1'b0;
    if (f3 == 3'd2 && (a % 4 != 0)) return 1'b0;
    return 1'b1;
  endfunction

  // Load result computed arithmetically from the cache word.
  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] word);
    logic [31:0] s;
    logic [31:0] b;
    logic [31:0] h;
    s = word >> ((a % 4) * 8);
    b = s % 256;
    h = s % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  // Store lane enables and replicated data.
  function automatic void modelStore(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] wd, output logic [3:0] be,
                                     output logic [31:0] w);
    case (f3)
      3'd0: begin be = 4'(1 << (a % 4)); w = (wd % 256) * 32'h0101_0101; end
      3'd1: begin be = 4'(3 << (a % 4)); w = (wd % 65536) * 32'h0001_0001; end
      default: begin be = 4'hF; w = wd; end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one operation end to end. lat = index of the ACCESS cycle in which
  // the cache answers (>= TIMEOUT means never); hold = cycles resp_ready low.
  task automatic applyStimulus(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [4:0] rd,
                               input logic [31:0] word, input int lat, input int hold);
    bit ok;
    bit expErr;
    logic [31:0] expData;
    logic [3:0]  expBe;
    logic [31:0] expW;
    int k;
    ok = modelOk(st, f3, addr);
    modelStore(f3, addr, wd, expBe, expW);
    if (!st) begin expBe = 4'h0; expW = 32'h0; end
    checkOutput("req_ready idle", 32'(reqReady), 32'd1);
    reqValid = 1'b1; reqStore = st; reqFunct3 = f3;
    reqAddr = addr; reqWdata = wd; reqRd = rd;
    @(posedge clk); @(negedge clk);
    reqValid = 1'b0; reqAddr = $urandom; reqWdata = $urandom; reqRd = 5'($urandom);
    if (!ok) begin
      expErr = 1'b1;
      expData = 32'h0;
      checkOutput("err resp_valid N+1", 32'(respValid), 32'd1);
    end else begin
      k = 0;
      while (!respValid && k < TIMEOUT + 4) begin
        checkOutput("dc_addr", dcAddr, addr & 32'hFFFF_FFFC);
        checkOutput("dc_rreq", 32'(dcRreq), 32'(!st));
        checkOutput("dc_wreq", 32'(dcWreq), 32'(st));
        checkOutput("dc_byte_enable", 32'(dcByteEnable), 32'(expBe));
        checkOutput("dc_wdata", dcWdata, expW);
        dcRdata  = word;
        dcRvalid = !st && (k == lat);
        dcWvalid = st && (k == lat);
        @(posedge clk); @(negedge clk);
        dcRvalid = 1'b0; dcWvalid = 1'b0; dcRdata = $urandom;
        k++;
      end
      checkOutput("access cycles", 32'(k), 32'((lat < TIMEOUT) ? lat + 1 : TIMEOUT));
      expErr  = (lat >= TIMEOUT);
      expData = (st || expErr) ? 32'h0 : modelLoad(f3, addr, word);
    end
    respReady = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      checkOutput("resp_valid", 32'(respValid), 32'd1);
      checkOutput("resp_data", respData, expData);
      checkOutput("resp_rd", 32'(respRd), st ? 32'd0 : 32'(rd));
      checkOutput("resp_err", 32'(respErr), 32'(expErr));
      checkOutput("req_ready busy", 32'(reqReady), 32'd0);
      checkOutput("dc req dropped", {30'd0, dcRreq, dcWreq}, 32'd0);
      if (h < hold) begin @(posedge clk); @(negedge clk); end
    end
    respReady = 1'b1;
    @(posedge clk); @(negedge clk);
    respReady = 1'b0;
    checkOutput("resp_valid after handshake", 32'(respValid), 32'd0);
    checkOutput("req_ready after handshake", 32'(reqReady), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " req_ready"}, 32'(reqReady), 32'd1);
    checkOutput({tag, " dc strobes"}, {30'd0, dcRreq, dcWreq}, 32'd0);
    checkOutput({tag, " dc_addr"}, dcAddr, 32'd0);
    checkOutput({tag, " dc_wdata"}, dcWdata, 32'd0);
    checkOutput({tag, " dc_byte_enable"}, 32'(dcByteEnable), 32'd0);
    checkOutput({tag, " resp_valid"}, 32'(respValid), 32'd0);
    checkOutput({tag, " resp_data"}, respData, 32'd0);
    checkOutput({tag, " resp_rd/err"}, {26'd0, respRd, respErr}, 32'd0);
  endtask

  initial begin
    bit st;
    logic [2:0] f3;
    logic [31:0] a;
    int lat;
    rstN = 1'b0; reqValid = 1'b0; reqStore = 1'b0; reqFunct3 = 3'd0;
    reqAddr = 32'h0; reqWdata = 32'h0; reqRd = 5'd0;
    dcRdata = 32'h0; dcRvalid = 1'b0; dcWvalid = 1'b0; respReady = 1'b0;
    @(negedge clk); @(negedge clk);
    checkAllZero("reset");
    rstN = 1'b1;
    @(negedge clk);

    $display("[TB] directed operations");
    applyStimulus(1'b0, 3'd2, 32'h0000_0010, 32'h0, 5'd7, 32'h8899_AABB, 0, 0);
    applyStimulus(1'b0, 3'd0, 32'h0000_0013, 32'h0, 5'd3, 32'h80FF_1234, 0, 0);
    applyStimulus(1'b0, 3'd4, 32'h0000_0013, 32'h0, 5'd4, 32'h80FF_1234, 0, 0);
    applyStimulus(1'b0, 3'd1, 32'h0000_0012, 32'h0, 5'd5, 32'h80FF_1234, 0, 0);
    applyStimulus(1'b0, 3'd5, 32'h0000_0012, 32'h0, 5'd6, 32'h80FF_1234, 2, 0);
    applyStimulus(1'b1, 3'd0, 32'h0000_0021, 32'h0000_00A5, 5'd9, 32'h0, 0, 0);
    applyStimulus(1'b1, 3'd1, 32'h0000_0022, 32'h0000_00A5, 5'd9, 32'h0, 1, 0);
    applyStimulus(1'b1, 3'd2, 32'h0000_0044, 32'hDEAD_BEEF, 5'd1, 32'h0, 0, 0);
    applyStimulus(1'b0, 3'd2, 32'h0000_0006, 32'h0, 5'd2, 32'h1234_5678, 0, 0);
    applyStimulus(1'b1, 3'd1, 32'h0000_0003, 32'h1234_5678, 5'd2, 32'h0, 0, 0);
    applyStimulus(1'b0, 3'd3, 32'h0000_0008, 32'h0, 5'd8, 32'h0, 0, 0);
    applyStimulus(1'b1, 3'd4, 32'h0000_0008, 32'h0, 5'd8, 32'h0, 0, 0);

    $display("[TB] timeout, late hit and backpressure");
    applyStimulus(1'b0, 3'd2, 32'h0000_0100, 32'h0, 5'd11, 32'hCAFE_F00D, 1000, 5);
    applyStimulus(1'b0, 3'd2, 32'h0000_0104, 32'h0, 5'd12, 32'hCAFE_F00D, TIMEOUT - 1, 0);
    applyStimulus(1'b1, 3'd2, 32'h0000_0108, 32'h5555_AAAA, 5'd13, 32'h0, 1000, 0);

    $display("[TB] reset during access");
    reqValid = 1'b1; reqStore = 1'b1; reqFunct3 = 3'd2;
    reqAddr = 32'h0000_0200; reqWdata = 32'h1357_9BDF; reqRd = 5'd1;
    @(posedge clk); @(negedge clk);
    reqValid = 1'b0;
    checkOutput("pre-reset dc_wreq", 32'(dcWreq), 32'd1);
    @(negedge clk); @(negedge clk);
    rstN = 1'b0;
    #1;
    checkAllZero("mid-op reset");
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post-reset resp_valid", 32'(respValid), 32'd0);
      checkOutput("post-reset req_ready", 32'(reqReady), 32'd1);
    end

    $display("[TB] randomized operations");
    for (int n = 0; n < 60; n++) begin
      st  = 1'($urandom);
      f3  = ($urandom_range(0, 3) == 0) ? 3'($urandom) :
            (st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
      a   = $urandom;
      lat = ($urandom_range(0, 9) == 0) ? 1000 : $urandom_range(0, 4);
      applyStimulus(st, f3, a, $urandom, 5'($urandom), $urandom, lat, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
